// File: rtl/lfsr_tap_search_ctrl_if.sv
// Bus bundle between the tap-search sequencer, its data memory, the LFSR
// accelerator and the core.
`timescale 1ns/1ps
interface lfsr_tap_search_ctrl_if #(
  parameter int AW = 8
);
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata;
  logic          lfsr_load_state;
  logic          lfsr_load_taps;
  logic          lfsr_enable_adv;
  logic [6:0]    lfsr_state0;
  logic [6:0]    lfsr_taps;
  logic [6:0]    lfsr_state;
  logic          busy;
  logic          done;
  logic          found;
  logic [3:0]    tap_idx;
  logic [6:0]    tap_out;
  logic [6:0]    seed_out;

  // Sequencer side
  modport slave (
    input  start, base_addr, mem_rdata, lfsr_state,
    output mem_addr, lfsr_load_state, lfsr_load_taps, lfsr_enable_adv,
           lfsr_state0, lfsr_taps, busy, done, found, tap_idx, tap_out, seed_out
  );

  // Core / memory / LFSR side
  modport master (
    output start, base_addr, mem_rdata, lfsr_state,
    input  mem_addr, lfsr_load_state, lfsr_load_taps, lfsr_enable_adv,
           lfsr_state0, lfsr_taps, busy, done, found, tap_idx, tap_out, seed_out
  );
endinterface

// File: rtl/lfsr_tap_search_ctrl.sv
// Tap-search sequencer: recovers the LFSR seed from the first ciphertext byte,
// then walks the tap table until one tap reproduces the SPACE preamble.
//
// state   | meaning
// IDLE    | waiting for start
// FETCH0  | read address = ciphertext byte 0
// SEED    | byte 0 returned; derive seed, reject if bit 7 cannot match
// LOAD    | load seed and TAP[k] into the LFSR
// ADV     | advance LFSR, fetch ciphertext byte i
// CHECK   | compare byte i against SPACE ^ LFSR state
// DONE    | one-cycle completion pulse
`timescale 1ns/1ps
module lfsr_tap_search_ctrl #(
  parameter int         PRE_LEN = 8,
  parameter int         AW      = 8,
  parameter logic [7:0] SPACE   = 8'h20
) (
  input logic clk,
  input logic rst_n,
  lfsr_tap_search_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH0, S_SEED, S_LOAD, S_ADV, S_CHECK, S_DONE
  } state_t;

  localparam logic [3:0] LAST_I = 4'(PRE_LEN - 1);
  localparam logic [3:0] LAST_K = 4'd8;

  state_t        state_q;
  logic [AW-1:0] base_q;
  logic [3:0]    k_q;
  logic [3:0]    i_q;
  logic [AW-1:0] mem_addr_q;
  logic          load_state_q;
  logic          load_taps_q;
  logic          enable_adv_q;
  logic [6:0]    state0_q;
  logic [6:0]    taps_q;
  logic          busy_q;
  logic          done_q;
  logic          found_q;
  logic [3:0]    tap_idx_q;
  logic [6:0]    tap_out_q;
  logic [6:0]    seed_q;
  logic [6:0]    seed_d;
  logic          byte_match;

  function automatic logic [6:0] tap_of(input logic [3:0] k);
    case (k)
      4'd0:    tap_of = 7'h60;
      4'd1:    tap_of = 7'h48;
      4'd2:    tap_of = 7'h78;
      4'd3:    tap_of = 7'h72;
      4'd4:    tap_of = 7'h6A;
      4'd5:    tap_of = 7'h69;
      4'd6:    tap_of = 7'h5C;
      4'd7:    tap_of = 7'h7E;
      4'd8:    tap_of = 7'h7B;
      default: tap_of = 7'h00;
    endcase
  endfunction

  // Seed derivation and per-byte preamble comparison
  always_comb begin
    seed_d     = bus.mem_rdata[6:0] ^ SPACE[6:0];
    byte_match = (bus.mem_rdata == (SPACE ^ {1'b0, bus.lfsr_state}));
  end

  // Sequencer FSM; every output is registered and the LFSR strobes default low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      k_q          <= '0;
      i_q          <= '0;
      mem_addr_q   <= '0;
      load_state_q <= 1'b0;
      load_taps_q  <= 1'b0;
      enable_adv_q <= 1'b0;
      state0_q     <= '0;
      taps_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      found_q      <= 1'b0;
      tap_idx_q    <= '0;
      tap_out_q    <= '0;
      seed_q       <= '0;
    end else begin
      load_state_q <= 1'b0;
      load_taps_q  <= 1'b0;
      enable_adv_q <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q    <= S_FETCH0;
            busy_q     <= 1'b1;
            found_q    <= 1'b0;
            tap_idx_q  <= '0;
            tap_out_q  <= '0;
            seed_q     <= '0;
            base_q     <= bus.base_addr;
            mem_addr_q <= bus.base_addr;
          end
        end
        S_FETCH0: state_q <= S_SEED;
        S_SEED: begin
          seed_q <= seed_d;
          k_q    <= '0;
          // Cipher bit 7 is always SPACE[7]; anything else rules out every tap
          if (bus.mem_rdata[7] != SPACE[7]) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q      <= S_LOAD;
            load_state_q <= 1'b1;
            load_taps_q  <= 1'b1;
            state0_q     <= seed_d;
            taps_q       <= tap_of(4'd0);
            i_q          <= 4'd1;
          end
        end
        S_LOAD: begin
          state_q      <= S_ADV;
          enable_adv_q <= 1'b1;
          mem_addr_q   <= base_q + AW'(i_q);
        end
        S_ADV: state_q <= S_CHECK;
        S_CHECK: begin
          if (!byte_match) begin
            if (k_q == LAST_K) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              k_q          <= k_q + 4'd1;
              state_q      <= S_LOAD;
              load_state_q <= 1'b1;
              load_taps_q  <= 1'b1;
              state0_q     <= seed_q;
              taps_q       <= tap_of(k_q + 4'd1);
              i_q          <= 4'd1;
            end
          end else if (i_q == LAST_I) begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            found_q   <= 1'b1;
            tap_idx_q <= k_q;
            tap_out_q <= tap_of(k_q);
          end else begin
            i_q          <= i_q + 4'd1;
            state_q      <= S_ADV;
            enable_adv_q <= 1'b1;
            mem_addr_q   <= base_q + AW'(i_q) + AW'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_addr        = mem_addr_q;
  assign bus.lfsr_load_state = load_state_q;
  assign bus.lfsr_load_taps  = load_taps_q;
  assign bus.lfsr_enable_adv = enable_adv_q;
  assign bus.lfsr_state0     = state0_q;
  assign bus.lfsr_taps       = taps_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.found           = found_q;
  assign bus.tap_idx         = tap_idx_q;
  assign bus.tap_out         = tap_out_q;
  assign bus.seed_out        = seed_q;

endmodule

// File: doc/lfsr_tap_search_ctrl.md
Name: lfsr_tap_search_ctrl

Overview:
- Sequencer for the 7-bit LFSR accelerator in the decryption program.
- Reads ciphertext whose known plaintext preamble is PRE_LEN bytes of SPACE (0x20).
- Derives the seed, then drives the LFSR's load_state/load_taps/enable_adv controls through the 9-entry tap table until a tap pattern reproduces the preamble.
- Reports the winning tap index, the tap pattern and the seed to the core.

Parameters:
PRE_LEN, 8, preamble length in bytes; legal 2..15
AW, 8, data memory address width
SPACE, 8'h20, preamble plaintext byte

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
base_addr  in  AW  address of ciphertext byte 0
mem_addr  out  AW  data memory read address (synchronous read, rdata valid next cycle)
mem_rdata  in  8  data memory read data
lfsr_load_state  out  1  to LFSR load_state
lfsr_load_taps  out  1  to LFSR load_taps
lfsr_enable_adv  out  1  to LFSR enable_adv
lfsr_state0  out  7  to LFSR state0
lfsr_taps  out  7  to LFSR taps
lfsr_state  in  7  from LFSR state
busy  out  1  high from start acceptance until the DONE cycle, inclusive
done  out  1  one-cycle completion pulse
found  out  1  a tap pattern matched; valid from done until next start
tap_idx  out  4  index 0..8 of the matching tap
tap_out  out  7  matching tap pattern
seed_out  out  7  derived seed

Behaviour:
- Reset (async assert, sync deassert use): state IDLE.
  - All outputs 0, including mem_addr, lfsr_* and results.
  - Reset mid-search aborts with no done pulse.
- Tap table, index 0..8: 0x60, 0x48, 0x78, 0x72, 0x6A, 0x69, 0x5C, 0x7E, 0x7B.
- Cipher model: cipher[i] = SPACE ^ {1'b0, s_i}.
  - s_0 = seed.
  - s_{i+1} = {s_i[5:0], ^(taps & s_i)}.
- IDLE: start=1 -> FETCH0. Clear found/tap_idx/tap_out/seed_out. busy=1 from next cycle.
- FETCH0: mem_addr = base_addr.
- SEED: capture seed = mem_rdata[6:0] ^ SPACE[6:0], k = 0.
  - If mem_rdata[7] != SPACE[7], no candidate can match: go to DONE with found=0, issuing no LFSR loads.
  - Otherwise go to LOAD.
- LOAD: lfsr_load_state=1, lfsr_load_taps=1 for exactly one cycle. lfsr_state0=seed, lfsr_taps=TAP[k], i = 1.
- ADV: lfsr_enable_adv=1 for one cycle, mem_addr = base_addr + i (mod 2^AW, wraps).
- CHECK: compare mem_rdata against SPACE ^ {1'b0, lfsr_state}.
  - Mismatch and k<8: k++, go to LOAD.
  - Mismatch and k==8: go to DONE with found=0.
  - Match and i<PRE_LEN-1: i++, go to ADV.
  - Match and i==PRE_LEN-1: go to DONE with found=1, tap_idx=k, tap_out=TAP[k].
- DONE: done=1 and busy=1 for one cycle, then IDLE. seed_out is valid at DONE regardless of found.
- First match wins; lower k has priority.
- All lfsr_* controls are 0 outside LOAD/ADV. lfsr_state0 and lfsr_taps hold their last values.
- start while busy is ignored. start in the DONE cycle is ignored.
- Latency, from the start-sampling edge to the done cycle: 3 + sum over tried candidates of (1 + 2·bytes_checked).
  - Full match at k=0 with PRE_LEN=8: 3 + 15 = 18 cycles.

Test Plan:
- Seed 0x01, taps 0x60, base 0x00, mem = 21 22 24 28 30 00 61 23 -> done after 18 cycles; found=1, tap_idx=0, tap_out=0x60, seed_out=0x01; exactly one load_taps pulse and 7 enable_adv pulses.
- mem[base]=0xA0 -> done 3 cycles after start; found=0, seed_out=0x00; no lfsr_load_* pulses.
- mem = 21 21 21 21 21 21 21 21 -> all 9 candidates fail at byte 1; found=0; 9 load_taps pulses; done at 3 + 9·3 = 30 cycles.
- Reference model encrypts with seed 0x55, taps 0x7B (idx 8), base 0xFC (address wrap) -> found=1, tap_idx=8, seed_out=0x55; mem_addr sequence wraps 0xFF->0x00.
- start pulsed mid-search -> ignored, result unchanged. rst_n low mid-search -> all outputs 0 immediately, no done. A fresh start then completes normally.
